// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, registered reads with valid,
// write-first bypass and a sequencer that loads mem[i] = i on request.
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_start,
  output logic                     init_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                     state_r, state_s;
  logic [ADDR_W-1:0]          cnt_r;
  logic                       init_busy_r;
  logic [DATA_W-1:0]          mem_r [DEPTH];
  logic [NUM_RD*DATA_W-1:0]   rd_data_r, rd_data_s;
  logic [NUM_RD-1:0]          rd_valid_r, rd_valid_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // Zero-extends or truncates an address to the data width for the default pattern.
  function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] ext;
    ext = {{DATA_W{1'b0}}, a};
    return ext[DATA_W-1:0];
  endfunction

  // Sequencer next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (init_start) state_s = INIT;
        else            state_s = IDLE;
      end
      INIT: begin
        if (cnt_r == LAST_ADDR) state_s = IDLE;
        else                    state_s = INIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, load counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {ADDR_W{1'b0}};
      init_busy_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      init_busy_r <= (state_s == INIT);
      if (state_r == INIT && state_s == INIT) cnt_r <= cnt_r + ADDR_W'(1);
      else                                    cnt_r <= {ADDR_W{1'b0}};
    end
  end

  // Storage array: the load sequence owns the write path while it runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else if (state_r == INIT) begin
      mem_r[cnt_r] <= addr_pattern(cnt_r);
    end else if (wr_en && in_range(wr_addr)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Per-port read selection; same-cycle write to the same address wins.
  always_comb begin
    rd_data_s  = rd_data_r;
    rd_valid_s = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (state_r == IDLE && rd_en[k]) begin
        rd_valid_s[k] = 1'b1;
        if (!in_range(rd_addr[k*ADDR_W +: ADDR_W]))
          rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        else if (wr_en && wr_addr == rd_addr[k*ADDR_W +: ADDR_W])
          rd_data_s[k*DATA_W +: DATA_W] = wr_data;
        else
          rd_data_s[k*DATA_W +: DATA_W] = mem_r[rd_addr[k*ADDR_W +: ADDR_W]];
      end else begin
        rd_valid_s[k] = 1'b0;
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {(NUM_RD*DATA_W){1'b0}};
      rd_valid_r <= {NUM_RD{1'b0}};
    end else begin
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
    end
  end

  assign init_busy = init_busy_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DEPTH=8, two read ports).
module tb_regfile_mp;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     init_start;
  logic                     init_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 2'b11;
      rd_addr = {3'(DEPTH - 1 - a), 3'(a)};
      step();
      check_eq({tag, "_data"}, 64'(rd_data), 64'h0);
      check_eq({tag, "_valid"}, 64'(rd_valid), 64'h3);
    end
    rd_en = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; init_start = 1'b0; wr_en = 1'b0; wr_addr = 3'd0;
    wr_data = 16'h0; rd_en = 2'b00; rd_addr = 6'd0;

    // 1. reset state and all-zero array
    step(); step();
    check_eq("rst_busy", 64'(init_busy), 64'h0);
    check_eq("rst_valid", 64'(rd_valid), 64'h0);
    check_eq("rst_data", 64'(rd_data), 64'h0);
    rst_n = 1'b1;
    step();
    read_all_zero("rst_rd");

    // 2. init sequence: 8 busy cycles, then mem[i] = i
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check_eq("init_busy0", 64'(init_busy), 64'h1);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      check_eq("init_busy", 64'(init_busy), 64'h1);
    end
    step();
    check_eq("init_done", 64'(init_busy), 64'h0);
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_en   = 2'b11;
      rd_addr = {3'(i + 4), 3'(i)};
      step();
      check_eq("init_pat", 64'(rd_data), {32'h0, 16'(i + 4), 16'(i)});
      check_eq("init_pat_v", 64'(rd_valid), 64'h3);
    end
    rd_en = 2'b00;

    // 3. write then dual read
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    rd_en = 2'b11; rd_addr = {3'd0, 3'd3};
    step();
    check_eq("wr_rd_data", 64'(rd_data), 64'h0000_BEEF);
    check_eq("wr_rd_valid", 64'(rd_valid), 64'h3);

    // 4. bypass on port1, then plain read on port0
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
    step();
    check_eq("byp_data", 64'(rd_data), 64'h1234_BEEF);
    check_eq("byp_valid", 64'(rd_valid), 64'h2);
    wr_en = 1'b0;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
    step();
    check_eq("byp_p0_data", 64'(rd_data), 64'h1234_1234);
    check_eq("byp_p0_valid", 64'(rd_valid), 64'h1);
    rd_en = 2'b00;
    step();
    check_eq("hold_data", 64'(rd_data), 64'h1234_1234);
    check_eq("hold_valid", 64'(rd_valid), 64'h0);

    // 5. init_start with write/read in IDLE, then blocked traffic during INIT
    init_start = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd1};
    step();
    init_start = 1'b0;
    check_eq("same_cyc_data", 64'(rd_data), 64'h1234_AAAA);
    check_eq("same_cyc_valid", 64'(rd_valid), 64'h1);
    check_eq("same_cyc_busy", 64'(init_busy), 64'h1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF;
    rd_en = 2'b11; rd_addr = {3'd2, 3'd2};
    for (int i = 1; i < DEPTH; i++) begin
      init_start = (i == 3);
      step();
      check_eq("blk_busy", 64'(init_busy), 64'h1);
      check_eq("blk_valid", 64'(rd_valid), 64'h0);
      check_eq("blk_data", 64'(rd_data), 64'h1234_AAAA);
    end
    init_start = 1'b0;
    step();
    check_eq("blk_done", 64'(init_busy), 64'h0);
    check_eq("blk_last_valid", 64'(rd_valid), 64'h0);
    wr_en = 1'b0;
    rd_en = 2'b11; rd_addr = {3'd1, 3'd2};
    step();
    check_eq("blk_mem", 64'(rd_data), 64'h0001_0002);
    check_eq("blk_mem_valid", 64'(rd_valid), 64'h3);
    rd_en = 2'b00;

    // 6. reset mid-INIT aborts and zeroes everything
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    step(); step(); step();
    check_eq("abort_pre_busy", 64'(init_busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(init_busy), 64'h0);
    check_eq("abort_valid", 64'(rd_valid), 64'h0);
    check_eq("abort_data", 64'(rd_data), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("abort_idle", 64'(init_busy), 64'h0);
    read_all_zero("abort_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
